// File: rtl/sha1_msg_feeder.sv
// sha1_msg_feeder: writer-side front end for the SHA-1 round pipeline.
// Collects one message as a byte stream, packs it big-endian into a single
// 512-bit block, appends the 0x80 pad byte, zero fill and the 64-bit bit
// length, then offers the finished block downstream with valid/ready.
// Messages longer than MAX_LEN are discarded and flagged with a one-cycle err.
module sha1_msg_feeder #(
    parameter int MAX_LEN = 55
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] msg_out,
    output logic [5:0]   out_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

    state_t       state;
    state_t       state_next;
    logic [511:0] blk;
    logic [511:0] blk_next;
    logic [5:0]   cnt;
    logic [5:0]   cnt_next;
    logic [5:0]   len;
    logic [5:0]   len_next;
    logic         err_next;
    logic [5:0]   cnt_inc;

    // Lowest bit of byte idx: word idx/4, with byte 0 of a word in its top lane.
    function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
        return {idx[5:2], 5'b0} + 9'd24 - {4'b0, idx[1:0], 3'b0};
    endfunction

    assign cnt_inc = cnt + 6'd1;

    // Next-state, buffer update and handshake outputs; everything defaults to hold.
    always_comb begin
        state_next = state;
        blk_next   = blk;
        cnt_next   = cnt;
        len_next   = len;
        err_next   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt < MAX_CNT) begin
                        blk_next[byte_lsb(cnt) +: 8] = in_data;
                        cnt_next = cnt_inc;
                        if (in_last) begin
                            // The pad byte lands at most at index 55, so it can
                            // never collide with the length words 14/15.
                            blk_next[byte_lsb(cnt_inc) +: 8] = 8'h80;
                            blk_next[479:448] = 32'd0;
                            blk_next[511:480] = {23'd0, cnt_inc, 3'd0};
                            len_next   = cnt_inc;
                            state_next = EMIT;
                        end
                    end else if (in_last) begin
                        err_next = 1'b1;
                        blk_next = '0;
                        cnt_next = '0;
                    end else begin
                        state_next = DROP;
                    end
                end
            end

            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    err_next   = 1'b1;
                    blk_next   = '0;
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Clearing here keeps every unused byte of the next block zero.
                    blk_next   = '0;
                    cnt_next   = '0;
                    len_next   = '0;
                    state_next = FILL;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial or pending message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            blk   <= '0;
            cnt   <= '0;
            len   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            blk   <= blk_next;
            cnt   <= cnt_next;
            len   <= len_next;
            err   <= err_next;
        end
    end

    assign msg_out = blk;
    assign out_len = len;

endmodule
